// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the operand-B issue path: opcodes, MuxOpB select
// encodings, skid-buffer state and the decoded-entry record.
package core_ctrl_pkg;

  localparam int OPB_SEL_W = 2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Encodings must match the MuxOpB input ordering in the datapath.
  typedef enum logic [OPB_SEL_W-1:0] {
    OPB_SEL_RSB = 2'd0,
    OPB_SEL_IMI = 2'd1,
    OPB_SEL_IMS = 2'd2,
    OPB_SEL_PC  = 2'd3
  } opb_sel_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    opb_sel_e opb_sel;
    logic     rs2_used;
    logic     illegal;
  } dec_entry_t;

  localparam dec_entry_t DEC_ENTRY_ZERO = '{opb_sel: OPB_SEL_RSB, rs2_used: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/opb_decode.sv
// Combinational opcode decode: RV32 instruction word to operand-B select,
// rs2 usage and illegal-opcode flag.
module opb_decode
  import core_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_entry_t  entry_o
);

  logic [6:0] opcode;
  logic       unused_inst;

  assign opcode      = inst_i[6:0];
  assign unused_inst = ^inst_i[31:7];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    entry_o = '{opb_sel: OPB_SEL_RSB, rs2_used: 1'b0, illegal: 1'b1};
    case (opcode)
      OPC_OP, OPC_BRANCH:
        entry_o = '{opb_sel: OPB_SEL_RSB, rs2_used: 1'b1, illegal: 1'b0};
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        entry_o = '{opb_sel: OPB_SEL_IMI, rs2_used: 1'b0, illegal: 1'b0};
      OPC_STORE:
        entry_o = '{opb_sel: OPB_SEL_IMS, rs2_used: 1'b1, illegal: 1'b0};
      OPC_AUIPC, OPC_LUI, OPC_JAL:
        entry_o = '{opb_sel: OPB_SEL_PC, rs2_used: 1'b0, illegal: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/opb_sel_issue_ctrl.sv
// Decode-to-execute stage for the operand-B path: decodes fetched instructions into a
// 2-entry skid buffer so io_in_ready depends only on registered state.
module opb_sel_issue_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [31:0]      io_in_inst,
  input  logic             io_flush,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [1:0]       io_out_opb_sel,
  output logic             io_out_rs2_used,
  output logic             io_out_illegal,
  output logic [CNT_W-1:0] io_issue_count
);

  buf_state_e       state_q, state_d;
  dec_entry_t       head_q, head_d;
  dec_entry_t       skid_q, skid_d;
  logic [CNT_W-1:0] count_q, count_d;
  dec_entry_t       dec_entry;
  logic             in_fire;
  logic             out_fire;

  opb_decode u_decode (
    .inst_i  (io_in_inst),
    .entry_o (dec_entry)
  );

  assign io_in_ready     = (state_q != BUF_TWO);
  assign io_out_valid    = (state_q != BUF_EMPTY);
  assign io_out_opb_sel  = head_q.opb_sel;
  assign io_out_rs2_used = head_q.rs2_used;
  assign io_out_illegal  = head_q.illegal;
  assign io_issue_count  = count_q;

  assign in_fire  = io_in_valid & io_in_ready & ~io_flush;
  assign out_fire = io_out_valid & io_out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;

    // Execute already saw a same-cycle handshake, so it counts even under flush.
    if (out_fire) count_d = count_q + CNT_W'(1);

    case (state_q)
      BUF_EMPTY: begin
        if (in_fire) begin
          head_d  = dec_entry;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_fire && out_fire) begin
          head_d = dec_entry;
        end else if (in_fire) begin
          skid_d  = dec_entry;
          state_d = BUF_TWO;
        end else if (out_fire) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (out_fire) begin
          head_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase

    if (io_flush) state_d = BUF_EMPTY;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= BUF_EMPTY;
      // NOTE: the entry registers are reset because the output fields must read 0 after reset.
      head_q  <= DEC_ENTRY_ZERO;
      skid_q  <= DEC_ENTRY_ZERO;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_opb_sel_issue_ctrl.sv
// Self-checking bench: decode vector table, scoreboard of expected entries and
// hand-written back-pressure, flush, wrap and reset sequences.
module tb_opb_sel_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_inst;
  logic        io_flush;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [1:0]  io_out_opb_sel;
  logic        io_out_rs2_used;
  logic        io_out_illegal;
  logic [15:0] io_issue_count;

  always #5 clk = ~clk;

  opb_sel_issue_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .io_in_valid     (io_in_valid),
    .io_in_ready     (io_in_ready),
    .io_in_inst      (io_in_inst),
    .io_flush        (io_flush),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_opb_sel  (io_out_opb_sel),
    .io_out_rs2_used (io_out_rs2_used),
    .io_out_illegal  (io_out_illegal),
    .io_issue_count  (io_issue_count)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic       rs2;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  sel;
    logic        rs2;
    logic        ill;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] exp_count;
  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] inst);
    exp_t e;
    case (inst[6:0])
      7'h33, 7'h63: e = '{2'd0, 1'b1, 1'b0};
      7'h13, 7'h03, 7'h67: e = '{2'd1, 1'b0, 1'b0};
      7'h23: e = '{2'd2, 1'b1, 1'b0};
      7'h17, 7'h37, 7'h6F: e = '{2'd3, 1'b0, 1'b0};
      default: e = '{2'd0, 1'b0, 1'b1};
    endcase
    return e;
  endfunction

  // One clock: compare outputs at the falling edge, then advance the model on the rising edge.
  task automatic step();
    logic        in_f, out_f;
    logic [31:0] inst;
    @(negedge clk);
    check("in_ready", io_in_ready, sb.size() < 2);
    check("out_valid", io_out_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      check("head_sel", io_out_opb_sel, sb[0].sel);
      check("head_rs2", io_out_rs2_used, sb[0].rs2);
      check("head_ill", io_out_illegal, sb[0].ill);
    end
    check("count", io_issue_count, exp_count);
    in_f  = io_in_valid && (sb.size() < 2) && !io_flush;
    out_f = (sb.size() > 0) && io_out_ready;
    inst  = io_in_inst;
    @(posedge clk);
    if (reset) begin
      sb.delete();
      exp_count = '0;
    end else begin
      if (out_f) begin
        void'(sb.pop_front());
        exp_count = exp_count + 16'd1;
      end
      if (io_flush) sb.delete();
      else if (in_f) sb.push_back(ref_decode(inst));
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
    io_in_valid  = v;
    io_in_inst   = inst;
    io_out_ready = rdy;
    io_flush     = fl;
  endtask

  initial begin
    vecs[0]  = '{32'h00B50533, 2'd0, 1'b1, 1'b0}; // add
    vecs[1]  = '{32'h00150513, 2'd1, 1'b0, 1'b0}; // addi
    vecs[2]  = '{32'h00A12023, 2'd2, 1'b1, 1'b0}; // sw
    vecs[3]  = '{32'h00000517, 2'd3, 1'b0, 1'b0}; // auipc
    vecs[4]  = '{32'h0000006F, 2'd3, 1'b0, 1'b0}; // jal
    vecs[5]  = '{32'h00B50463, 2'd0, 1'b1, 1'b0}; // beq
    vecs[6]  = '{32'h00052503, 2'd1, 1'b0, 1'b0}; // lw
    vecs[7]  = '{32'h00008067, 2'd1, 1'b0, 1'b0}; // jalr
    vecs[8]  = '{32'h12345537, 2'd3, 1'b0, 1'b0}; // lui
    vecs[9]  = '{32'h0000007B, 2'd0, 1'b0, 1'b1}; // unknown opcode
    vecs[10] = '{32'h00C58633, 2'd0, 1'b1, 1'b0}; // add after illegal
    vecs[11] = '{32'hFFFFFFFF, 2'd0, 1'b0, 1'b1}; // all-ones word

    exp_count = '0;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    check("rst_in_ready", io_in_ready, 1'b1);
    check("rst_out_valid", io_out_valid, 1'b0);
    check("rst_count", io_issue_count, 16'd0);
    check("rst_sel", io_out_opb_sel, 2'd0);
    check("rst_rs2", io_out_rs2_used, 1'b0);
    check("rst_ill", io_out_illegal, 1'b0);

    // Streamed decode table: each entry must be at the head the cycle after acceptance.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].inst, 1'b1, 1'b0);
      step();
      check("tbl_valid", io_out_valid, 1'b1);
      check("tbl_sel", io_out_opb_sel, vecs[i].sel);
      check("tbl_rs2", io_out_rs2_used, vecs[i].rs2);
      check("tbl_ill", io_out_illegal, vecs[i].ill);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("tbl_count", io_issue_count, 16'd12);
    check("tbl_drained", io_out_valid, 1'b0);

    // Back-pressure: two accepted, third stalls; head stable for 5 cycles.
    drive(1'b1, 32'h00150513, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00A12023, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000006F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", io_in_ready, 1'b0);
      check("bp_head_sel", io_out_opb_sel, 2'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("bp_ready_back", io_in_ready, 1'b1);
    check("bp_second_sel", io_out_opb_sel, 2'd2);
    step();
    check("bp_count", io_issue_count, 16'd14);
    check("bp_empty", io_out_valid, 1'b0);

    // Flush in TWO with a same-cycle consume and a same-cycle offer.
    drive(1'b1, 32'h00B50533, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00000517, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h12345537, 1'b1, 1'b1);
    step();
    check("fl_valid", io_out_valid, 1'b0);
    check("fl_count", io_issue_count, 16'd15);
    check("fl_ready", io_in_ready, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("fl_not_taken", io_out_valid, 1'b0);

    // Stream until the counter sits at its maximum, then one more consume wraps it.
    drive(1'b1, 32'h00150513, 1'b1, 1'b0);
    for (int i = 0; i < 70000 && exp_count != 16'hFFFE; i++) step();
    check("wrap_reached", exp_count, 16'hFFFE);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("wrap_max", io_issue_count, 16'hFFFF);
    drive(1'b1, 32'h00A12023, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("wrap_zero", io_issue_count, 16'd0);

    // Reset while in ONE with a pending consume: no handshake completes.
    drive(1'b1, 32'h00B50533, 1'b0, 1'b0);
    step();
    check("pre_rst_valid", io_out_valid, 1'b1);
    check("pre_rst_count", io_issue_count, 16'd0 + exp_count);
    drive(1'b1, 32'h00150513, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("mid_rst_valid", io_out_valid, 1'b0);
    check("mid_rst_count", io_issue_count, 16'd0);
    check("mid_rst_sel", io_out_opb_sel, 2'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
